// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose
//   Turns one asynchronous, active-high board reset into a staggered set of
//   reset outputs. The deassertion edge of rstIn is synchronised to clkIn
//   through a short flop chain. After a minimum hold time, the outputs are
//   released one at a time in ascending index order, with a fixed gap between
//   them. A synchronous software reset request restarts the hold/release
//   sequence without going back through the synchroniser.
//
// Parameters
//   SYNC_STAGES      : synchroniser depth on the deassertion path (2..8)
//   NUM_OUT          : number of sequenced reset outputs (1..16)
//   HOLD_CYCLES      : clocks from synchronised deassertion to the first
//                      release (1..1024)
//   GAP_CYCLES       : clocks between successive releases (1..1024)
//   RST_OUT_POLARITY : asserted level of every rstOut bit
//
// Ports
//   clkIn    in   1        : the single clock
//   rstIn    in   1        : asynchronous active-high reset; it asserts
//                            everything immediately and wins over all else
//   swRstIn  in   1        : synchronous software reset request, sampled on
//                            the rising edge; it is ignored while in RESET
//   rstOut   out  NUM_OUT  : sequenced resets, asserted at RST_OUT_POLARITY
//   doneOut  out  1        : high once every rstOut bit has been released
//   stateOut out  2        : RESET=0, HOLD=1, RELEASE=2, RUN=3
//
// Every output comes straight from a flop, so no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int   SYNC_STAGES      = 2,
    parameter int   NUM_OUT          = 4,
    parameter int   HOLD_CYCLES      = 16,
    parameter int   GAP_CYCLES       = 8,
    parameter logic RST_OUT_POLARITY = 1'b1
) (
    input  logic               clkIn,
    input  logic               rstIn,
    input  logic               swRstIn,
    output logic [NUM_OUT-1:0] rstOut,
    output logic               doneOut,
    output logic [1:0]         stateOut
);

    // -------------------------------------------------------------------------
    // Parameter legality (elaboration-time)
    // -------------------------------------------------------------------------
    if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync_stages
        $error("reset_sequencer: SYNC_STAGES=%0d outside legal range 2..8", SYNC_STAGES);
    end
    if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
        $error("reset_sequencer: NUM_OUT=%0d outside legal range 1..16", NUM_OUT);
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 1024) begin : g_bad_hold_cycles
        $error("reset_sequencer: HOLD_CYCLES=%0d outside legal range 1..1024", HOLD_CYCLES);
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 1024) begin : g_bad_gap_cycles
        $error("reset_sequencer: GAP_CYCLES=%0d outside legal range 1..1024", GAP_CYCLES);
    end

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    // The counter only ever has to reach HOLD_CYCLES-1 or GAP_CYCLES-1, so
    // clog2 of the larger one is enough bits. It is forced to at least 1 bit
    // so that the degenerate 1-cycle case still has a legal vector.
    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [NUM_OUT-1:0] ALL_ASSERTED = {NUM_OUT{RST_OUT_POLARITY}};

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [NUM_OUT-1:0]     rst_out_q;
    logic [NUM_OUT-1:0]     rst_out_d;
    logic                   done_q;
    logic                   done_d;

    // The synchroniser output is still asserted while any stage holds a 1.
    logic sync_rst;
    assign sync_rst = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Release pattern
    // -------------------------------------------------------------------------
    // Released bits always form a contiguous run starting at index 0. Each
    // release therefore shifts the current pattern up by one bit and fills
    // bit 0 with the deasserted level. Shifting an all-asserted vector gives
    // the first release. Each later shift frees exactly one more bit. A
    // released bit can never be driven back to asserted by this path.
    logic [NUM_OUT-1:0] rst_out_shift;

    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_shift
        if (gi == 0) begin : g_first
            assign rst_out_shift[gi] = ~RST_OUT_POLARITY;
        end else begin : g_next
            assign rst_out_shift[gi] = rst_out_q[gi-1];
        end
    end

    // The top bit of the shifted pattern shows whether this release is the
    // final one. This also covers NUM_OUT=1: the very first release is then
    // the last, so HOLD goes straight to RUN.
    logic last_release;
    assign last_release = (rst_out_shift[NUM_OUT-1] == ~RST_OUT_POLARITY);

    // -------------------------------------------------------------------------
    // Synchroniser next state
    // -------------------------------------------------------------------------
    // rstIn sets every stage asynchronously. Once rstIn is low, a zero is
    // shifted in on each edge, so the last stage clears on edge SYNC_STAGES.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        case (state_q)
            ST_RESET: begin
                // Software reset is deliberately not looked at here. Only
                // the synchroniser can move the FSM out of RESET.
                rst_out_d = ALL_ASSERTED;
                done_d    = 1'b0;
                cnt_d     = '0;
                if (!sync_rst) begin
                    state_d = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (swRstIn) begin
                    // Re-entering HOLD with a cleared counter on every edge
                    // that samples swRstIn high pins the counter at 0 for as
                    // long as the request stays high.
                    rst_out_d = ALL_ASSERTED;
                    done_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d     = '0;
                    rst_out_d = rst_out_shift;
                    if (last_release) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (swRstIn) begin
                    rst_out_d = ALL_ASSERTED;
                    done_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d     = '0;
                    rst_out_d = rst_out_shift;
                    if (last_release) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (swRstIn) begin
                    rst_out_d = ALL_ASSERTED;
                    done_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                end
            end

            default: begin
                rst_out_d = ALL_ASSERTED;
                done_d    = 1'b0;
                cnt_d     = '0;
                state_d   = ST_RESET;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            sync_q    <= '1;
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            rst_out_q <= ALL_ASSERTED;
            done_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (registered only)
    // -------------------------------------------------------------------------
    assign rstOut   = rst_out_q;
    assign doneOut  = done_q;
    assign stateOut = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Two instances share one clock and one stimulus stream:
//   dut_a : default parameters (S=2, N=4, HOLD=16, GAP=8, active-high)
//   dut_b : corner parameters  (S=3, N=1, HOLD=1,  GAP=1, active-low)
//
// The reference model keeps a single "base" edge number per instance:
//   - after rstIn falls, base = (first edge after the fall) + S
//   - after a software reset that is honoured on edge E, base = E
// From the base, plain arithmetic gives the expected outputs at edge k:
//   - bit i is released when k >= base + HOLD + i*GAP
//   - done is set once the last bit is released
//   - the state is RESET while k < base
// A software request on edge k is honoured when k > base and rstIn is low.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int S_A = 2;
    localparam int N_A = 4;
    localparam int H_A = 16;
    localparam int G_A = 8;
    localparam bit P_A = 1'b1;

    localparam int S_B = 3;
    localparam int N_B = 1;
    localparam int H_B = 1;
    localparam int G_B = 1;
    localparam bit P_B = 1'b0;

    logic clk    = 1'b0;
    logic rst_in = 1'b1;
    logic sw_in  = 1'b0;

    logic [N_A-1:0] rst_out_a;
    logic           done_a;
    logic [1:0]     state_a;
    logic [N_B-1:0] rst_out_b;
    logic           done_b;
    logic [1:0]     state_b;

    always #5 clk = ~clk;

    reset_sequencer #(
        .SYNC_STAGES(S_A), .NUM_OUT(N_A), .HOLD_CYCLES(H_A),
        .GAP_CYCLES(G_A), .RST_OUT_POLARITY(P_A)
    ) dut_a (
        .clkIn(clk), .rstIn(rst_in), .swRstIn(sw_in),
        .rstOut(rst_out_a), .doneOut(done_a), .stateOut(state_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(S_B), .NUM_OUT(N_B), .HOLD_CYCLES(H_B),
        .GAP_CYCLES(G_B), .RST_OUT_POLARITY(P_B)
    ) dut_b (
        .clkIn(clk), .rstIn(rst_in), .swRstIn(sw_in),
        .rstOut(rst_out_b), .doneOut(done_b), .stateOut(state_b)
    );

    int total = 0;
    int bad   = 0;

    int edge_cnt = 0;
    int base_a   = 0;
    int base_b   = 0;

    // Edge numbers of interesting events, used for the directed timing checks
    int   rel0_a_edge;
    int   done_a_edge;
    int   done_b_edge;
    logic prev_r0_a;
    logic prev_done_a;
    logic prev_done_b;

    // ---------------------------------------------------------------- checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d, t=%0t)", tag, got, exp, edge_cnt, $time);
        end
    endtask

    // ------------------------------------------------------- reference model
    function automatic logic [15:0] exp_rst(input int k, input int base, input bit inrst,
                                            input int n, input int h, input int g, input bit pol);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i] = (!inrst && k >= base + h + i * g) ? ~pol : pol;
        end
        return v;
    endfunction

    function automatic bit exp_done(input int k, input int base, input bit inrst,
                                    input int n, input int h, input int g);
        return !inrst && (k >= base + h + (n - 1) * g);
    endfunction

    function automatic logic [1:0] exp_state(input int k, input int base, input bit inrst,
                                             input int n, input int h, input int g);
        if (inrst || k < base)                return 2'd0;
        else if (exp_done(k, base, inrst, n, h, g)) return 2'd3;
        else if (k >= base + h)               return 2'd2;
        else                                  return 2'd1;
    endfunction

    task automatic check_all();
        check("a_rstOut",   32'(rst_out_a), 32'(exp_rst(edge_cnt, base_a, rst_in, N_A, H_A, G_A, P_A)));
        check("a_doneOut",  32'(done_a),    32'(exp_done(edge_cnt, base_a, rst_in, N_A, H_A, G_A)));
        check("a_stateOut", 32'(state_a),   32'(exp_state(edge_cnt, base_a, rst_in, N_A, H_A, G_A)));
        check("b_rstOut",   32'(rst_out_b), 32'(exp_rst(edge_cnt, base_b, rst_in, N_B, H_B, G_B, P_B)));
        check("b_doneOut",  32'(done_b),    32'(exp_done(edge_cnt, base_b, rst_in, N_B, H_B, G_B)));
        check("b_stateOut", 32'(state_b),   32'(exp_state(edge_cnt, base_b, rst_in, N_B, H_B, G_B)));
    endtask

    task automatic clear_tracking();
        rel0_a_edge = -1;
        done_a_edge = -1;
        done_b_edge = -1;
        prev_r0_a   = rst_out_a[0];
        prev_done_a = done_a;
        prev_done_b = done_b;
    endtask

    // One clock: update the model on the rising edge, then compare on the
    // falling edge (away from the active edge).
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        if (!rst_in && sw_in) begin
            if (edge_cnt > base_a) base_a = edge_cnt;
            if (edge_cnt > base_b) base_b = edge_cnt;
        end
        @(negedge clk);
        check_all();
        if (prev_r0_a === P_A && rst_out_a[0] === ~P_A) rel0_a_edge = edge_cnt;
        if (!prev_done_a && done_a === 1'b1) done_a_edge = edge_cnt;
        if (!prev_done_b && done_b === 1'b1) done_b_edge = edge_cnt;
        prev_r0_a   = rst_out_a[0];
        prev_done_a = done_a;
        prev_done_b = done_b;
    endtask

    task automatic set_rst(input logic v);
        rst_in = v;
        if (v) begin
            #1;
            check_all();   // the reset must take effect asynchronously
        end else begin
            base_a = edge_cnt + 1 + S_A;
            base_b = edge_cnt + 1 + S_B;
        end
    endtask

    // -------------------------------------------------------------- stimulus
    initial begin
        int f;
        int e;
        int sw_len;
        int r;

        // Software reset held high during rstIn: no effect; then the
        // default release timing follows.
        sw_in = 1'b1;
        clear_tracking();
        repeat (3) step();
        sw_in = 1'b0;
        set_rst(1'b0);
        f = edge_cnt + 1;
        clear_tracking();
        repeat (50) step();
        check("s1_rel0_edge",  32'(rel0_a_edge - f + 1), 32'd19);
        check("s1_done_edge",  32'(done_a_edge - f + 1), 32'd43);
        check("s1_b_done_edge", 32'(done_b_edge - f + 1), 32'd5);
        check("s1_run_state",  32'(state_a), 32'd3);
        $display("scenario power-on: edge=%0d total=%0d", edge_cnt, total);

        // An asynchronous pulse mid-sequence restarts everything.
        set_rst(1'b1);
        repeat (2) step();
        set_rst(1'b0);
        f = edge_cnt + 1;
        repeat (29) step();
        set_rst(1'b1);
        check("s2_pulse_rstOut", 32'(rst_out_a), 32'hF);
        check("s2_pulse_done",   32'(done_a), 32'd0);
        check("s2_pulse_state",  32'(state_a), 32'd0);
        #1;
        set_rst(1'b0);
        f = edge_cnt + 1;
        clear_tracking();
        repeat (50) step();
        check("s2_rel0_edge", 32'(rel0_a_edge - f + 1), 32'd19);
        check("s2_done_edge", 32'(done_a_edge - f + 1), 32'd43);
        $display("scenario mid-sequence pulse: edge=%0d total=%0d", edge_cnt, total);

        // Software reset in RUN for five edges.
        clear_tracking();
        sw_in = 1'b1;
        step();
        check("s3_sw_assert", 32'(rst_out_a), 32'hF);
        check("s3_sw_state",  32'(state_a), 32'd1);
        repeat (4) step();
        e = edge_cnt;
        sw_in = 1'b0;
        repeat (45) step();
        check("s3_rel0_edge",   32'(rel0_a_edge), 32'(e + 16));
        check("s3_done_edge",   32'(done_a_edge), 32'(e + 40));
        check("s3_b_done_edge", 32'(done_b_edge), 32'(e + 1));
        $display("scenario software reset: E=%0d total=%0d", e, total);

        // rstIn and swRstIn together: reset wins.
        sw_in = 1'b1;
        set_rst(1'b1);
        step();
        check("s4_state_reset", 32'(state_a), 32'd0);
        sw_in = 1'b0;
        step();
        set_rst(1'b0);
        f = edge_cnt + 1;
        clear_tracking();
        repeat (50) step();
        check("s4_done_edge", 32'(done_a_edge - f + 1), 32'd43);
        $display("scenario simultaneous resets: edge=%0d total=%0d", edge_cnt, total);

        // Random mix of held resets, short pulses and software requests.
        sw_len = 0;
        repeat (2500) begin
            r = $urandom_range(0, 999);
            if (rst_in) begin
                if (r < 300) set_rst(1'b0);
            end else if (r < 8) begin
                set_rst(1'b1);
            end else if (r < 16) begin
                set_rst(1'b1);
                #1;
                set_rst(1'b0);
            end
            if (sw_len > 0) begin
                sw_in = 1'b1;
                sw_len--;
            end else begin
                sw_in = 1'b0;
                if (r >= 985) sw_len = $urandom_range(1, 6);
            end
            step();
        end
        $display("scenario random: edge=%0d total=%0d", edge_cnt, total);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on the deassertion path; legal range 2..8.
REQ-002 SHALL have parameter NUM_OUT, default 4, the number of sequenced reset outputs; legal range 1..16.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, the minimum number of clocks between synchronised deassertion and the first release; legal range 1..1024.
REQ-004 SHALL have parameter GAP_CYCLES, default 8, the number of clocks between successive output releases; legal range 1..1024.
REQ-005 SHALL have parameter RST_OUT_POLARITY, default 1'b1, the asserted level of every rstOut bit.
REQ-006 SHALL have port clkIn, input, 1 bit: the single clock.
REQ-007 SHALL have port rstIn, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port swRstIn, input, 1 bit: synchronous software reset request, active-high, sampled on the clkIn rising edge.
REQ-009 SHALL have port rstOut, output, NUM_OUT bits: the sequenced reset outputs, each asserted at RST_OUT_POLARITY.
REQ-010 SHALL have port doneOut, output, 1 bit: high when all outputs are released.
REQ-011 SHALL have port stateOut, output, 2 bits: FSM state, encoded RESET=0, HOLD=1, RELEASE=2, RUN=3.
REQ-012 SHALL reject any parameter value outside its legal range with an elaboration-time error.

Function
REQ-013 SHALL drive every output from a register; no output SHALL have a combinational path from any input.
REQ-014 SHALL implement a SYNC_STAGES-deep synchroniser chain: all stages are set asynchronously by rstIn, and the chain shifts in the deasserted value on each edge, so that syncRst deasserts at edge S (S = SYNC_STAGES, edges counted from the first rising edge after rstIn falls).
REQ-015 SHALL, in state RESET, hold all rstOut bits asserted and move to HOLD, with the counter at 0, on the first edge at which syncRst is deasserted (edge S+1).
REQ-016 SHALL, in state HOLD, increment the counter each edge and, on the edge where counter == HOLD_CYCLES-1, deassert rstOut[0], clear the counter and enter RELEASE.
REQ-017 SHALL, in state RELEASE, deassert rstOut[i+1] every GAP_CYCLES edges after rstOut[i], in ascending index order, and never reassert a released bit.
REQ-018 SHALL enter RUN and set doneOut=1 on the same edge that deasserts rstOut[NUM_OUT-1].
REQ-019 SHALL, when NUM_OUT=1, go directly HOLD->RUN on the release edge, deasserting rstOut[0] and setting doneOut on that edge.
REQ-020 SHALL give release timing from rstIn as follows: rstOut[i] deasserts at edge S+1+HOLD_CYCLES+i*GAP_CYCLES.
REQ-021 SHALL, when swRstIn is sampled high in HOLD, RELEASE or RUN: on that edge assert all rstOut bits, clear doneOut, clear the counter and enter HOLD.
REQ-022 SHALL, while swRstIn remains high, hold the counter at 0.
REQ-023 SHALL, after a software reset, deassert rstOut[0] at edge E+HOLD_CYCLES, where E is the last edge that sampled swRstIn high.
REQ-024 SHALL ignore swRstIn in state RESET.
REQ-025 SHALL size the counter as clog2(max(HOLD_CYCLES, GAP_CYCLES)) bits, minimum 1; the counter SHALL never wrap.

Reset
REQ-026 SHALL, while rstIn is high, immediately and asynchronously set rstOut to all bits RST_OUT_POLARITY, doneOut=0, stateOut=0 (RESET), counter=0 and every synchroniser stage to asserted.
REQ-027 SHALL give rstIn priority over swRstIn and all FSM activity, including rstIn asserted in any state mid-sequence.
REQ-028 SHALL hold state RESET until rstIn is low and the synchroniser chain has flushed.

Verification
REQ-029 The bench SHALL cover default parameters: rstIn high 3 cycles then low -> rstOut[0..3] deassert at edges 19/27/35/43; doneOut=1 and stateOut=3 at edge 43.
REQ-030 The bench SHALL cover mid-sequence async reset: rstIn pulsed between clock edges at edge 30 -> within that cycle rstOut=4'b1111, doneOut=0, stateOut=0; the full sequence then restarts from edge 1.
REQ-031 The bench SHALL cover software reset in RUN: swRstIn high for 5 edges, last at edge E -> all outputs assert on the first edge; rstOut[0] releases at E+16; doneOut at E+40.
REQ-032 The bench SHALL cover software reset ignored in RESET: swRstIn held high while rstIn is high -> no effect; timing is identical to REQ-029.
REQ-033 The bench SHALL cover the parameter corners: NUM_OUT=1, HOLD_CYCLES=1, SYNC_STAGES=3, RST_OUT_POLARITY=0 -> rstOut=0 in reset; rstOut goes 1 and doneOut goes 1 at edge 5.
REQ-034 The bench SHALL cover simultaneous events: rstIn asserted on the same edge that swRstIn is sampled high -> the RESET state is taken and swRstIn has no effect.
